// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and constants for the unified-memory arbiter.
//
//   owner_e      : which port the memory response in flight belongs to
//   STARVE_CNT_W : width of the fetch anti-starvation counter
//   owner_of()   : maps this cycle's grants onto the owner of next cycle's data
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // The grant logic guarantees at most one of the two is set, so the
    // ordering here only matters for readability.
    function automatic owner_e owner_of(input logic if_gnt, input logic d_gnt);
        owner_e own;
        own = OWN_NONE;
        if (d_gnt) begin
            own = OWN_D;
        end else if (if_gnt) begin
            own = OWN_IF;
        end
        return own;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the fetch port, the data port, the memory port and the stall
//   outputs of the unified-memory arbiter.
//
//   modport slave  : arbiter view (requests and mem_rdata in; grants,
//                    responses, memory drive and stalls out)
//   modport master : environment view (pipeline, hazard unit and memory)
//
//   Fetch port  : if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//   Data port   : d_req, d_we, d_addr, d_wdata, d_be -> d_gnt, d_rvalid, d_rdata
//   Memory port : mem_en, mem_we, mem_addr, mem_wdata, mem_be <- mem_rdata
//   Stalls      : stall_if, stall_mem
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int AW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [3:0]    d_be;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata;

    logic          stall_if;
    logic          stall_mem;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata,
        input  stall_if, stall_mem
    );

endinterface

// File: rtl/mem_arbiter_starve_ctr.sv
// -----------------------------------------------------------------------------
// arb_starve_ctr
//   Saturating count of consecutive cycles a pending fetch has been refused.
//
//   clk, reset : clock, synchronous active-high reset
//   inc        : fetch pending and refused this cycle
//   clr        : fetch granted or not requested this cycle (wins over inc)
//   limit      : saturation value
//   at_limit   : count has reached limit; the fetch must win next contention
// -----------------------------------------------------------------------------
module arb_starve_ctr
    import mem_arb_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inc,
    input  logic                    clr,
    input  logic [STARVE_CNT_W-1:0] limit,
    output logic                    at_limit
);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == limit);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port, synchronous-read memory between instruction fetch
//   and the data (MEM-stage) port. At most one access is issued per cycle;
//   the read data returning one cycle later is steered to the issuing port.
//   Data accesses win contention unless the fetch has already been refused
//   STARVE_LIMIT cycles in a row, in which case the fetch is forced through.
//
//   Parameters : STARVE_LIMIT (1..15), AW (address width)
//   clk        : clock, rising-edge
//   reset      : synchronous, active-high
//   bus        : mem_arbiter_if.slave (fetch port, data port, memory port,
//                stall_if / stall_mem for the hazard unit)
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 32
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic          if_gnt;
    logic          d_gnt;
    logic          at_limit;
    logic          starve_inc;
    logic          starve_clr;

    owner_e        owner_q;
    owner_e        owner_d;

    logic [AW-1:0] addr_hold_q;
    logic [AW-1:0] addr_hold_d;
    logic [31:0]   wdata_hold_q;
    logic [31:0]   wdata_hold_d;

    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_we;

    // Grant: data first, unless a fetch has waited out its allowance.
    always_comb begin
        d_gnt  = bus.d_req & ~(bus.if_req & at_limit);
        if_gnt = bus.if_req & ~d_gnt;
    end

    // Clearing on "granted or not requesting" is exactly the complement of
    // "requesting and refused".
    assign starve_inc = bus.if_req & ~if_gnt;
    assign starve_clr = ~starve_inc;

    arb_starve_ctr u_starve_ctr (
        .clk      (clk),
        .reset    (reset),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .limit    (LIMIT),
        .at_limit (at_limit)
    );

    // Memory drive. With no grant the address and write data repeat the last
    // issued values so the memory pins do not toggle on idle cycles.
    always_comb begin
        mem_addr  = addr_hold_q;
        mem_wdata = wdata_hold_q;
        mem_be    = 4'b0000;
        mem_we    = 1'b0;
        if (d_gnt) begin
            mem_addr  = bus.d_addr;
            mem_wdata = bus.d_wdata;
            mem_we    = bus.d_we;
            mem_be    = bus.d_we ? bus.d_be : 4'b0000;
        end else if (if_gnt) begin
            mem_addr = bus.if_addr;
        end
    end

    always_comb begin
        owner_d      = owner_of(if_gnt, d_gnt);
        addr_hold_d  = mem_addr;
        wdata_hold_d = mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= OWN_NONE;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
        end else begin
            owner_q      <= owner_d;
            addr_hold_q  <= addr_hold_d;
            wdata_hold_q <= wdata_hold_d;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.mem_en    = if_gnt | d_gnt;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_be    = mem_be;

    // Gating with reset drops a response whose access was granted in the
    // cycle just before reset took hold.
    assign bus.if_rvalid = (owner_q == OWN_IF) & ~reset;
    assign bus.d_rvalid  = (owner_q == OWN_D) & ~reset;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;

    assign bus.stall_if  = bus.if_req & ~if_gnt;
    assign bus.stall_mem = bus.d_req & ~d_gnt;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    typedef struct {
        int          due;
        logic [1:0]  port;      // {if, d}
        logic        chk_data;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;

    rsp_t        exp_q[$];
    logic [31:0] ref_mem[256];
    logic [31:0] env_mem[256];
    int          refused = 0;
    logic        last_i = 1'b0;
    logic        last_d = 1'b0;

    mem_arbiter_if #(.AW(32)) bus ();

    mem_arbiter #(.STARVE_LIMIT(LIMIT), .AW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory on the DUT's memory port.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_be[b]) env_mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end
            end
            bus.mem_rdata <= env_mem[bus.mem_addr[9:2]];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Response monitor: one expected response (or none) per cycle.
    always @(negedge clk) begin
        rsp_t       r;
        logic [1:0] exp_v;
        exp_v = 2'b00;
        r.chk_data = 1'b0;
        r.data = '0;
        r.port = 2'b00;
        r.due = 0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            r = exp_q.pop_front();
            exp_v = r.port;
        end
        chk("rvalid{if,d}", {62'd0, bus.if_rvalid, bus.d_rvalid}, {62'd0, exp_v});
        if (exp_v != 2'b00 && r.chk_data) begin
            chk("rdata", {32'd0, (exp_v[1] ? bus.if_rdata : bus.d_rdata)}, {32'd0, r.data});
        end
    end

    // One bus cycle: drive, let the grant settle, compare against the
    // reference rules, record the expected response.
    task automatic cycle(input logic rst, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dwe, input logic [31:0] da,
                         input logic [31:0] dwd, input logic [3:0] dbe);
        logic        ei, ed;
        logic [31:0] word;
        @(posedge clk);
        #1;
        reset       = rst;
        bus.if_req  = ir;
        bus.if_addr = ia;
        bus.d_req   = dr;
        bus.d_we    = dwe;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
        bus.d_be    = dbe;
        if (rst) begin
            exp_q.delete();
        end
        @(negedge clk);
        // Data wins unless fetch has been refused LIMIT cycles running.
        ed = dr && !(ir && refused >= LIMIT);
        ei = ir && !ed;
        chk("gnt/stall{ig,dg,si,sm}",
            {60'd0, bus.if_gnt, bus.d_gnt, bus.stall_if, bus.stall_mem},
            {60'd0, ei, ed, ir && !ei, dr && !ed});
        chk("mem{en,we,be}", {58'd0, bus.mem_en, bus.mem_we, bus.mem_be},
            {58'd0, ei || ed, ed && dwe, (ed && dwe) ? dbe : 4'b0000});
        if (ei || ed) chk("mem_addr", {32'd0, bus.mem_addr}, {32'd0, ed ? da : ia});
        if (ed && dwe) chk("mem_wdata", {32'd0, bus.mem_wdata}, {32'd0, dwd});
        last_i = ei;
        last_d = ed;
        if (rst) begin
            refused = 0;
        end else begin
            refused = (ir && !ei) ? ((refused < LIMIT) ? refused + 1 : LIMIT) : 0;
            if (ei) exp_q.push_back('{cyc + 1, 2'b10, 1'b1, ref_mem[ia[9:2]]});
            if (ed) begin
                word = ref_mem[da[9:2]];
                if (dwe) begin
                    for (int b = 0; b < 4; b++) begin
                        if (dbe[b]) ref_mem[da[9:2]][8*b +: 8] = dwd[8*b +: 8];
                    end
                end
                exp_q.push_back('{cyc + 1, 2'b01, !dwe, word});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        logic        pi, pd, pwe;
        logic [31:0] pia, pda, pwd;
        logic [3:0]  pbe;

        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 32'h0;
            env_mem[i] = 32'h0;
        end
        ref_mem[4] = 32'h0050_0093;
        env_mem[4] = 32'h0050_0093;
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        bus.d_be = '0;
        bus.mem_rdata = '0;

        // Reset, then idle: nothing granted, no responses.
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        idle(2);

        // Fetch alone.
        cycle(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        idle(1);

        // Partial store then load-back.
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b1100);
        idle(1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        idle(1);
        chk("store_load_word", {32'd0, ref_mem[64]}, {32'd0, 32'hDEAD_0000});

        // Continuous contention: fetch forced through every LIMIT+1 cycles.
        for (int i = 0; i < 12; i++)
            cycle(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h100 + 4 * i, 32'h0, 4'h0);
        idle(1);

        // Alternating fetch / load.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) cycle(1'b0, 1'b1, 4 * i, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            else            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        end
        idle(1);

        // Load granted, reset next cycle: response dropped, fetch immediate.
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        idle(1);

        // Fetch refused 3 cycles, dropped, then a fresh full wait.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h48, 32'h0, 4'h0);
        idle(1);

        // Random traffic; requests held until granted, occasionally withdrawn.
        pi = 1'b0; pd = 1'b0; pwe = 1'b0;
        pia = '0; pda = '0; pwd = '0; pbe = '0;
        for (int n = 0; n < 1500; n++) begin
            if (!pi) begin
                pi  = ($urandom_range(0, 1) == 1);
                pia = {22'd0, 8'($urandom_range(0, 63)), 2'b00};
            end else if ($urandom_range(0, 15) == 0) begin
                pi = 1'b0;
            end
            if (!pd) begin
                pd  = ($urandom_range(0, 2) != 0);
                pwe = $urandom_range(0, 1) == 1;
                pda = {22'd0, 8'($urandom_range(0, 63)), 2'b00};
                pwd = $urandom;
                pbe = 4'($urandom_range(1, 15));
            end else if ($urandom_range(0, 15) == 0) begin
                pd = 1'b0;
            end
            cycle(1'b0, pi, pia, pd, pwe, pda, pwd, pbe);
            if (last_i) pi = 1'b0;
            if (last_d) pd = 1'b0;
        end
        idle(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
